// File: rtl/ccr_flag_unit.sv
// Condition-code register with per-opcode flag enables, jump-clear and a LIFO shadow stack.
// Optional macro CCR_FWD_EN: ccr_fwd presents the combinational next ccr instead of the registered one.
module ccr_flag_unit #(
  parameter int OPC_W      = 4,
  parameter int SAVE_DEPTH = 2,
  parameter int CNT_W      = $clog2(SAVE_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [OPC_W-1:0] op_code,
  input  logic [1:0]       ra,
  input  logic             sf1,
  input  logic [3:0]       alu_flags,
  input  logic             jmp_taken,
  input  logic [1:0]       jmp_sel,
  input  logic             int_save,
  input  logic             rti_restore,
  output logic [3:0]       ccr,
  output logic [3:0]       ccr_fwd,
  output logic [CNT_W-1:0] stk_cnt,
  output logic             stk_full,
  output logic             stk_empty,
  output logic             ovf_err,
  output logic             udf_err
);

  logic [3:0]       ccr_q, ccr_d;
  logic [3:0]       stack_q [SAVE_DEPTH];
  logic [3:0]       stack_d [SAVE_DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic [3:0] flagEn;
  logic [3:0] nxtFlags;
  logic [3:0] stackTop;
  logic       isFull;
  logic       isEmpty;

  assign isFull  = (cnt_q == CNT_W'(SAVE_DEPTH));
  assign isEmpty = (cnt_q == '0);

  // Full-width compares make any nonzero upper opcode bits fall through to "no flags".
  always_comb begin
    flagEn = 4'b0000;
    if (valid && !sf1) begin
      if (op_code == OPC_W'(4'b0010) || op_code == OPC_W'(4'b0011)) begin
        flagEn = 4'b1111;
      end else if (op_code == OPC_W'(4'b0100) || op_code == OPC_W'(4'b0101)) begin
        flagEn = 4'b0011;
      end else if (op_code == OPC_W'(4'b0110)) begin
        flagEn = 4'b0100;
      end else if (op_code == OPC_W'(4'b1000)) begin
        flagEn = ra[1] ? 4'b1111 : 4'b0011;
      end
    end
  end

  always_comb begin
    nxtFlags = (ccr_q & ~flagEn) | (alu_flags & flagEn);
    if (jmp_taken && jmp_sel != 2'b11) begin
      nxtFlags[jmp_sel] = 1'b0;
    end
  end

  always_comb begin
    stackTop = 4'b0000;
    for (int i = 0; i < SAVE_DEPTH; i++) begin
      if (cnt_q == CNT_W'(i + 1)) begin
        stackTop = stack_q[i];
      end
    end
  end

  // A save always wins over a simultaneous restore, so the restore is simply not seen.
  always_comb begin
    ccr_d = nxtFlags;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    for (int i = 0; i < SAVE_DEPTH; i++) begin
      stack_d[i] = stack_q[i];
    end
    if (int_save) begin
      if (isFull) begin
        ovf_d = 1'b1;
      end else begin
        for (int i = 0; i < SAVE_DEPTH; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            stack_d[i] = nxtFlags;
          end
        end
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (rti_restore) begin
      if (isEmpty) begin
        udf_d = 1'b1;
      end else begin
        ccr_d = stackTop;
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ccr_q <= 4'b0000;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      for (int i = 0; i < SAVE_DEPTH; i++) begin
        stack_q[i] <= 4'b0000;
      end
    end else begin
      ccr_q <= ccr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      for (int i = 0; i < SAVE_DEPTH; i++) begin
        stack_q[i] <= stack_d[i];
      end
    end
  end

  assign ccr       = ccr_q;
  assign stk_cnt   = cnt_q;
  assign stk_full  = isFull;
  assign stk_empty = isEmpty;
  assign ovf_err   = ovf_q;
  assign udf_err   = udf_q;

`ifdef CCR_FWD_EN
  assign ccr_fwd = ccr_d;
`else
  assign ccr_fwd = ccr_q;
`endif

endmodule

// File: tb/tb_ccr_flag_unit.sv
// Scoreboard bench for ccr_flag_unit: directed scenarios, then randomized traffic vs a queue-based model.
module tb_ccr_flag_unit;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic [3:0]    op_code;
  logic [1:0]    ra;
  logic          sf1;
  logic [3:0]    alu_flags;
  logic          jmp_taken;
  logic [1:0]    jmp_sel;
  logic          int_save;
  logic          rti_restore;
  logic [3:0]    ccr;
  logic [3:0]    ccr_fwd;
  logic [CW-1:0] stk_cnt;
  logic          stk_full;
  logic          stk_empty;
  logic          ovf_err;
  logic          udf_err;

  ccr_flag_unit #(.OPC_W(4), .SAVE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .valid(valid), .op_code(op_code), .ra(ra), .sf1(sf1),
    .alu_flags(alu_flags), .jmp_taken(jmp_taken), .jmp_sel(jmp_sel),
    .int_save(int_save), .rti_restore(rti_restore), .ccr(ccr), .ccr_fwd(ccr_fwd),
    .stk_cnt(stk_cnt), .stk_full(stk_full), .stk_empty(stk_empty),
    .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ccr;
    int         cnt;
    logic       ovf;
    logic       udf;
  } exp_t;

  exp_t       expQ[$];
  int         checks = 0;
  int         errors = 0;

  logic [3:0] mCcr;
  logic [3:0] mStack[$];
  logic       mOvf;
  logic       mUdf;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Flags written by each instruction class, straight from the opcode table.
  function automatic logic [3:0] writtenFlags(input int op, input int sub);
    bit zn, c, v;
    zn = (op == 2 || op == 3 || op == 4 || op == 5 || op == 8);
    v  = (op == 2 || op == 3 || (op == 8 && sub >= 2));
    c  = v || (op == 6);
    return {v, c, zn, zn};
  endfunction

  task automatic modelReset();
    mCcr = 4'b0000;
    mStack.delete();
    mOvf = 1'b0;
    mUdf = 1'b0;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [1:0] sub,
                               input logic s1, input logic [3:0] alu, input logic jt,
                               input logic [1:0] js, input logic sv, input logic rs);
    logic [3:0] mask;
    logic [3:0] nxt;
    logic [3:0] newCcr;
    logic [3:0] oldCcr;
    exp_t       e;
    @(negedge clk);
    valid = v; op_code = op; ra = sub; sf1 = s1; alu_flags = alu;
    jmp_taken = jt; jmp_sel = js; int_save = sv; rti_restore = rs;
    mask = (v && !s1) ? writtenFlags(int'(op), int'(sub)) : 4'b0000;
    nxt  = mCcr;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) nxt[b] = alu[b];
    end
    if (jt && js != 2'd3) nxt[js] = 1'b0;
    oldCcr = mCcr;
    newCcr = nxt;
    if (sv) begin
      if (mStack.size() < DEPTH) mStack.push_back(nxt);
      else mOvf = 1'b1;
    end else if (rs) begin
      if (mStack.size() > 0) newCcr = mStack.pop_back();
      else mUdf = 1'b1;
    end
    mCcr = newCcr;
    #1;
`ifdef CCR_FWD_EN
    checkOutput("ccr_fwd", 32'(ccr_fwd), 32'(newCcr));
`else
    checkOutput("ccr_fwd", 32'(ccr_fwd), 32'(oldCcr));
`endif
    e.ccr = mCcr; e.cnt = mStack.size(); e.ovf = mOvf; e.udf = mUdf;
    expQ.push_back(e);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 1'b0, 2'd3, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    valid = 1'b0; int_save = 1'b0; rti_restore = 1'b0; jmp_taken = 1'b0;
    #1;
    checkOutput("rst_ccr", 32'(ccr), 32'd0);
    checkOutput("rst_cnt", 32'(stk_cnt), 32'd0);
    checkOutput("rst_err", 32'({ovf_err, udf_err}), 32'd0);
    checkOutput("rst_empty", 32'(stk_empty), 32'd1);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every clock edge retires the oldest issued stimulus.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("ccr", 32'(ccr), 32'(e.ccr));
      checkOutput("stk_cnt", 32'(stk_cnt), 32'(e.cnt));
      checkOutput("stk_full", 32'(stk_full), 32'(e.cnt == DEPTH));
      checkOutput("stk_empty", 32'(stk_empty), 32'(e.cnt == 0));
      checkOutput("ovf_err", 32'(ovf_err), 32'(e.ovf));
      checkOutput("udf_err", 32'(udf_err), 32'(e.udf));
    end
  end

  initial begin
    rst = 1'b1; valid = 1'b0; op_code = 4'd0; ra = 2'd0; sf1 = 1'b0; alu_flags = 4'd0;
    jmp_taken = 1'b0; jmp_sel = 2'd3; int_save = 1'b0; rti_restore = 1'b0;
    modelReset();
    #12;
    doReset();

    // Basic update and sf1 suppression.
    applyStimulus(1, 4'b0010, 0, 0, 4'b1111, 0, 3, 0, 0);
    applyStimulus(1, 4'b0010, 0, 1, 4'b0000, 0, 3, 0, 0);
    idle();
    checkOutput("dir_sf1_hold", 32'(ccr), 32'hF);
    applyStimulus(1, 4'b0011, 0, 0, 4'b0000, 0, 3, 0, 0);
    applyStimulus(1, 4'b0100, 0, 0, 4'b1111, 0, 3, 0, 0);
    applyStimulus(1, 4'b0110, 0, 0, 4'b0100, 0, 3, 0, 0);
    idle();
    checkOutput("dir_partial", 32'(ccr), 32'h7);
    // Jump clear beats a simultaneous ALU set.
    applyStimulus(1, 4'b0010, 0, 0, 4'b0001, 0, 3, 0, 0);
    applyStimulus(1, 4'b0010, 0, 0, 4'b0001, 1, 0, 0, 0);
    idle();
    checkOutput("dir_clear_wins", 32'(ccr), 32'h0);
    // Stack overflow then underflow.
    applyStimulus(1, 4'b0010, 0, 0, 4'b0101, 0, 3, 1, 0);
    applyStimulus(1, 4'b0010, 0, 0, 4'b1010, 0, 3, 1, 0);
    applyStimulus(1, 4'b0010, 0, 0, 4'b1111, 0, 3, 1, 0);
    idle();
    checkOutput("dir_ovf", 32'({ovf_err, stk_cnt}), 32'({1'b1, CW'(2)}));
    applyStimulus(0, 4'b0000, 0, 0, 4'b0000, 0, 3, 0, 1);
    idle();
    checkOutput("dir_pop_b", 32'(ccr), 32'hA);
    applyStimulus(0, 4'b0000, 0, 0, 4'b0000, 0, 3, 0, 1);
    idle();
    checkOutput("dir_pop_a", 32'(ccr), 32'h5);
    applyStimulus(0, 4'b0000, 0, 0, 4'b0000, 0, 3, 0, 1);
    idle();
    checkOutput("dir_udf", 32'({udf_err, stk_cnt}), 32'({1'b1, CW'(0)}));
    // Save and restore together with one entry stacked.
    doReset();
    applyStimulus(1, 4'b1000, 2, 0, 4'b1001, 0, 3, 1, 0);
    applyStimulus(1, 4'b1000, 1, 0, 4'b0010, 0, 3, 1, 1);
    idle();
    checkOutput("dir_save_prio", 32'({udf_err, stk_cnt}), 32'({1'b0, CW'(2)}));

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 2'($urandom),
                      $urandom_range(0, 3) == 0, 4'($urandom), 1'($urandom),
                      2'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
      end
    end

    idle();
    repeat (2) @(negedge clk);
    checkOutput("drain", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
